// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM read/write burst arbiter.
//   arb_state_e : scheduler FSM states
//   grant_e     : which side owned the most recent grant
//   *_DEF       : default widths for address, burst length and FIFO fill count
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned LEN_W_DEF  = 10;
  localparam int unsigned USED_W_DEF = 10;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrBusy,
    StRdReq,
    StRdBusy
  } arb_state_e;

  typedef enum logic {
    GntWr = 1'b0,
    GntRd = 1'b1
  } grant_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Frame pointer for one side (write drain or read refill) of the SDRAM arbiter.
// Ports:
//   clk, rst              : clock, async active-high reset
//   init_done             : low => pointer held at min_addr, bank 0
//   pingpang_en           : two-buffer mode; when low the bank is held at 0
//   min_addr, max_addr    : frame window (min < max)
//   len                   : burst length added after each completed burst
//   load                  : synchronous reload to min_addr, bank 0
//   active                : this side is in its REQ or BUSY state
//   done                  : this side's burst completed this cycle
//   wrap_bank             : bank value taken on a frame wrap (ping-pong mode)
//   addr, bank            : current pointer and bank
//   frame_done            : one-cycle pulse the cycle after a wrapping burst
module sdram_addr_gen #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              pingpang_en,
  input  logic [ADDR_W-1:0] min_addr,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              load,
  input  logic              active,
  input  logic              done,
  input  logic              wrap_bank,
  output logic [ADDR_W-1:0] addr,
  output logic              bank,
  output logic              frame_done
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bank_q, bank_d;
  logic              sup_q, sup_d;
  logic              fd_q, fd_d;
  logic [ADDR_W:0]   next_addr;

  // One extra bit so the sum cannot overflow before the wrap compare.
  assign next_addr = {1'b0, addr_q} + (ADDR_W+1)'(len);

  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    sup_d  = sup_q;
    fd_d   = 1'b0;
    if (!init_done) begin
      addr_d = min_addr;
      bank_d = 1'b0;
      sup_d  = 1'b0;
    end else if (load) begin
      addr_d = min_addr;
      bank_d = 1'b0;
      // A burst in flight must not advance the freshly loaded pointer; a
      // burst ending this very cycle leaves nothing to suppress.
      sup_d  = active && !done;
    end else if (done) begin
      sup_d = 1'b0;
      if (!sup_q) begin
        if (next_addr >= {1'b0, max_addr}) begin
          addr_d = min_addr;
          fd_d   = 1'b1;
          bank_d = wrap_bank;
        end else begin
          addr_d = next_addr[ADDR_W-1:0];
        end
      end
    end
    if (!pingpang_en) begin
      bank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      bank_q <= 1'b0;
      sup_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
      sup_q  <= sup_d;
      fd_q   <= fd_d;
    end
  end

  assign addr       = addr_q;
  assign bank       = bank_q;
  assign frame_done = fd_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Shares the SDRAM controller command port between the write-FIFO drain and
// the read-FIFO refill. One burst request is outstanding at a time; frame
// pointers advance after each completed burst, and in ping-pong mode the read
// side follows the frame buffer the write side is not filling.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   init_done                   : SDRAM ready; low forces idle and reloads pointers
//   wr_used, rd_used            : FIFO fill counts
//   wr_len, rd_len              : burst lengths
//   wr/rd_min_addr, _max_addr   : frame windows
//   wr_load, rd_load            : pointer reload strobes
//   read_valid, pingpang_en     : read enable, two-buffer mode
//   cmd_wr_req, cmd_rd_req      : registered burst requests
//   cmd_addr, cmd_ba, cmd_len   : request attributes, stable while requesting
//   cmd_ack, cmd_done           : controller handshake strobes
//   wr_frame_done, rd_frame_done: frame wrap pulses
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned USED_W = USED_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [USED_W-1:0] wr_used,
  input  logic [USED_W-1:0] rd_used,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic              pingpang_en,
  output logic              cmd_wr_req,
  output logic              cmd_rd_req,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [1:0]        cmd_ba,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              wr_frame_done,
  output logic              rd_frame_done
);

  localparam int unsigned CmpW = (USED_W > LEN_W) ? USED_W : LEN_W;

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              cmd_wr_req_q, cmd_wr_req_d;
  logic              cmd_rd_req_q, cmd_rd_req_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [1:0]        cmd_ba_q, cmd_ba_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_bank, rd_bank;
  logic              wr_elig, rd_elig;
  logic              wr_active, rd_active;
  logic              wr_done, rd_done;

  assign wr_elig   = CmpW'(wr_used) >= CmpW'(wr_len);
  assign rd_elig   = read_valid && (CmpW'(rd_used) < CmpW'(rd_len));
  assign wr_active = (state_q == StWrReq) || (state_q == StWrBusy);
  assign rd_active = (state_q == StRdReq) || (state_q == StRdBusy);
  assign wr_done   = (state_q == StWrBusy) && cmd_done;
  assign rd_done   = (state_q == StRdBusy) && cmd_done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_wr_req_d = cmd_wr_req_q;
    cmd_rd_req_d = cmd_rd_req_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_ba_d     = cmd_ba_q;
    cmd_len_d    = cmd_len_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the side not granted last wins.
        if (wr_elig && (!rd_elig || (last_grant_q == GntRd))) begin
          state_d      = StWrReq;
          last_grant_d = GntWr;
          cmd_wr_req_d = 1'b1;
          cmd_addr_d   = wr_addr;
          cmd_ba_d     = {1'b0, wr_bank};
          cmd_len_d    = wr_len;
        end else if (rd_elig) begin
          state_d      = StRdReq;
          last_grant_d = GntRd;
          cmd_rd_req_d = 1'b1;
          cmd_addr_d   = rd_addr;
          cmd_ba_d     = {1'b0, rd_bank};
          cmd_len_d    = rd_len;
        end
      end
      StWrReq: begin
        if (cmd_ack) begin
          state_d      = StWrBusy;
          cmd_wr_req_d = 1'b0;
        end
      end
      StRdReq: begin
        if (cmd_ack) begin
          state_d      = StRdBusy;
          cmd_rd_req_d = 1'b0;
        end
      end
      StWrBusy, StRdBusy: begin
        if (cmd_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!init_done) begin
      state_d      = StIdle;
      cmd_wr_req_d = 1'b0;
      cmd_rd_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GntRd;
      cmd_wr_req_q <= 1'b0;
      cmd_rd_req_q <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_ba_q     <= '0;
      cmd_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_wr_req_q <= cmd_wr_req_d;
      cmd_rd_req_q <= cmd_rd_req_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_ba_q     <= cmd_ba_d;
      cmd_len_q    <= cmd_len_d;
    end
  end

  assign cmd_wr_req = cmd_wr_req_q;
  assign cmd_rd_req = cmd_rd_req_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_len    = cmd_len_q;

  // Both sides take ~wr_bank on a wrap: the writer flips buffers, and the
  // reader lands on the frame the writer most recently completed.
  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_wr_gen (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .pingpang_en (pingpang_en),
    .min_addr    (wr_min_addr),
    .max_addr    (wr_max_addr),
    .len         (wr_len),
    .load        (wr_load),
    .active      (wr_active),
    .done        (wr_done),
    .wrap_bank   (~wr_bank),
    .addr        (wr_addr),
    .bank        (wr_bank),
    .frame_done  (wr_frame_done)
  );

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_rd_gen (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .pingpang_en (pingpang_en),
    .min_addr    (rd_min_addr),
    .max_addr    (rd_max_addr),
    .len         (rd_len),
    .load        (rd_load),
    .active      (rd_active),
    .done        (rd_done),
    .wrap_bank   (~wr_bank),
    .addr        (rd_addr),
    .bank        (rd_bank),
    .frame_done  (rd_frame_done)
  );

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed self-checking bench for sdram_rw_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_sdram_rw_arbiter;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic [9:0]  wr_used, rd_used;
  logic [9:0]  wr_len, rd_len;
  logic [23:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
  logic        wr_load, rd_load;
  logic        read_valid, pingpang_en;
  logic        cmd_wr_req, cmd_rd_req;
  logic [23:0] cmd_addr;
  logic [1:0]  cmd_ba;
  logic [9:0]  cmd_len;
  logic        cmd_ack, cmd_done;
  logic        wr_frame_done, rd_frame_done;

  int n_tests;
  int n_fail;

  sdram_rw_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .init_done     (init_done),
    .wr_used       (wr_used),
    .rd_used       (rd_used),
    .wr_len        (wr_len),
    .rd_len        (rd_len),
    .wr_min_addr   (wr_min_addr),
    .wr_max_addr   (wr_max_addr),
    .rd_min_addr   (rd_min_addr),
    .rd_max_addr   (rd_max_addr),
    .wr_load       (wr_load),
    .rd_load       (rd_load),
    .read_valid    (read_valid),
    .pingpang_en   (pingpang_en),
    .cmd_wr_req    (cmd_wr_req),
    .cmd_rd_req    (cmd_rd_req),
    .cmd_addr      (cmd_addr),
    .cmd_ba        (cmd_ba),
    .cmd_len       (cmd_len),
    .cmd_ack       (cmd_ack),
    .cmd_done      (cmd_done),
    .wr_frame_done (wr_frame_done),
    .rd_frame_done (rd_frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wait (bounded) for any request to appear.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!(cmd_wr_req || cmd_rd_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!(cmd_wr_req || cmd_rd_req)) begin
      n_fail++;
      $display("FAIL %s timeout: no request after %0d cycles, required one", name, n);
    end
  endtask

  // Act as the controller for one burst and check its attributes.
  task automatic serve(input string name, input logic is_rd, input logic [23:0] exp_addr,
                       input logic [1:0] exp_ba, input logic exp_fd);
    logic [1:0] exp_req;
    logic [9:0] exp_len;
    exp_req = is_rd ? 2'b01 : 2'b10;
    exp_len = is_rd ? rd_len : wr_len;
    wait_req(name);
    n_tests++;
    if ({cmd_wr_req, cmd_rd_req} !== exp_req) begin
      n_fail++;
      $display("FAIL %s req {wr,rd}: got %b required %b", name, {cmd_wr_req, cmd_rd_req}, exp_req);
    end
    n_tests++;
    if (cmd_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL %s addr: got %0d required %0d", name, cmd_addr, exp_addr);
    end
    n_tests++;
    if (cmd_ba !== exp_ba) begin
      n_fail++;
      $display("FAIL %s ba: got %0d required %0d", name, cmd_ba, exp_ba);
    end
    n_tests++;
    if (cmd_len !== exp_len) begin
      n_fail++;
      $display("FAIL %s len: got %0d required %0d", name, cmd_len, exp_len);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    n_tests++;
    if ({cmd_wr_req, cmd_rd_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s req after ack: got %b required 00", name, {cmd_wr_req, cmd_rd_req});
    end
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_tests++;
    if ({wr_frame_done, rd_frame_done} !== {exp_fd && !is_rd, exp_fd && is_rd}) begin
      n_fail++;
      $display("FAIL %s frame_done {wr,rd}: got %b required %b", name,
               {wr_frame_done, rd_frame_done}, {exp_fd && !is_rd, exp_fd && is_rd});
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_tests++;
    if ({cmd_wr_req, cmd_rd_req, cmd_addr, cmd_ba, cmd_len, wr_frame_done, rd_frame_done}
        !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got req=%b addr=%0d ba=%0d len=%0d fd=%b required all 0",
               name, {cmd_wr_req, cmd_rd_req}, cmd_addr, cmd_ba, cmd_len,
               {wr_frame_done, rd_frame_done});
    end
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Write side eligible but SDRAM not initialised: nothing may be issued.
    wr_used = 10'd600;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_wr_req, cmd_rd_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL no_init req: got %b required 00", {cmd_wr_req, cmd_rd_req});
      end
    end
  endtask

  task automatic test_write_only();
    init_done = 1'b1;
    serve("wr0", 1'b0, 24'd0, 2'd0, 1'b0);
    serve("wr1", 1'b0, 24'd512, 2'd0, 1'b0);
    serve("wr2", 1'b0, 24'd1024, 2'd0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (wr_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_fd_width: got %b required 0", wr_frame_done);
    end
    serve("wr3", 1'b0, 24'd0, 2'd1, 1'b0);
    wr_used = 10'd0;
  endtask

  task automatic test_pingpong_read();
    read_valid = 1'b1;
    serve("pp_rd0", 1'b1, 24'd0, 2'd0, 1'b0);
    serve("pp_rd1", 1'b1, 24'd512, 2'd0, 1'b1);
    serve("pp_rd2", 1'b1, 24'd0, 2'd0, 1'b0);
    read_valid = 1'b0;
    wr_used = 10'd600;
    serve("pp_wr0", 1'b0, 24'd512, 2'd1, 1'b0);
    serve("pp_wr1", 1'b0, 24'd1024, 2'd1, 1'b1);
    wr_used = 10'd0;
    read_valid = 1'b1;
    serve("pp_rd3", 1'b1, 24'd512, 2'd0, 1'b1);
    serve("pp_rd4", 1'b1, 24'd0, 2'd1, 1'b0);
    read_valid = 1'b0;
  endtask

  task automatic test_tie();
    wr_used = 10'd600;
    read_valid = 1'b1;
    serve("tie_wr0", 1'b0, 24'd0, 2'd0, 1'b0);
    serve("tie_rd0", 1'b1, 24'd512, 2'd1, 1'b1);
    serve("tie_wr1", 1'b0, 24'd512, 2'd0, 1'b0);
    serve("tie_rd1", 1'b1, 24'd0, 2'd1, 1'b0);
    wr_used = 10'd0;
    read_valid = 1'b0;
  endtask

  task automatic test_no_pingpong();
    pingpang_en = 1'b0;
    wr_used = 10'd600;
    serve("np_wr0", 1'b0, 24'd1024, 2'd0, 1'b1);
    serve("np_wr1", 1'b0, 24'd0, 2'd0, 1'b0);
    wr_used = 10'd0;
    read_valid = 1'b1;
    serve("np_rd0", 1'b1, 24'd512, 2'd0, 1'b1);
    serve("np_rd1", 1'b1, 24'd0, 2'd0, 1'b0);
    read_valid = 1'b0;
    pingpang_en = 1'b1;
  endtask

  task automatic test_load_mid_burst();
    wr_used = 10'd600;
    wait_req("load_req");
    n_tests++;
    if ({cmd_wr_req, cmd_addr} !== {1'b1, 24'd512}) begin
      n_fail++;
      $display("FAIL load_req wr/addr: got %b/%0d required 1/512", cmd_wr_req, cmd_addr);
    end
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_tests++;
    if (wr_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fd: got %b required 0", wr_frame_done);
    end
    serve("load_next", 1'b0, 24'd0, 2'd0, 1'b0);
    wr_used = 10'd0;
  endtask

  task automatic test_init_drop();
    read_valid = 1'b1;
    wait_req("drop_req");
    n_tests++;
    if ({cmd_rd_req, cmd_addr} !== {1'b1, 24'd512}) begin
      n_fail++;
      $display("FAIL drop_req rd/addr: got %b/%0d required 1/512", cmd_rd_req, cmd_addr);
    end
    init_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_rd_req: got %b required 0", cmd_rd_req);
    end
    @(negedge clk);
    @(negedge clk);
    init_done = 1'b1;
    serve("drop_rd_min", 1'b1, 24'd0, 2'd0, 1'b0);
    read_valid = 1'b0;
    wr_used = 10'd600;
    serve("drop_wr_min", 1'b0, 24'd0, 2'd0, 1'b0);
    wr_used = 10'd0;
  endtask

  task automatic test_async_reset();
    wr_used = 10'd600;
    wait_req("rst_req");
    n_tests++;
    if ({cmd_wr_req, cmd_addr} !== {1'b1, 24'd512}) begin
      n_fail++;
      $display("FAIL rst_req wr/addr: got %b/%0d required 1/512", cmd_wr_req, cmd_addr);
    end
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    serve("after_rst", 1'b0, 24'd0, 2'd0, 1'b0);
    wr_used = 10'd0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    init_done   = 1'b0;
    wr_used     = 10'd0;
    rd_used     = 10'd0;
    wr_len      = 10'd512;
    rd_len      = 10'd512;
    wr_min_addr = 24'd0;
    wr_max_addr = 24'd1536;
    rd_min_addr = 24'd0;
    rd_max_addr = 24'd1024;
    wr_load     = 1'b0;
    rd_load     = 1'b0;
    read_valid  = 1'b0;
    pingpang_en = 1'b1;
    cmd_ack     = 1'b0;
    cmd_done    = 1'b0;
    test_reset();
    test_write_only();
    test_pingpong_read();
    test_tie();
    test_no_pingpong();
    test_load_mid_burst();
    test_init_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
